// File: rtl/alu_unit_pkg.sv
// Shared types for the ALU execute unit: opcode encoding, FSM state and the debug view.
// The multiply opcodes are only executed when the build defines ALU_MUL_EN.
package alu_unit_pkg;

    localparam int OP_WIDTH = 6;

    typedef enum logic [OP_WIDTH-1:0] {
        OP_ADD    = 6'd0,
        OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU,
        OP_ADDI   = 6'd10,
        OP_ANDI, OP_ORI, OP_XORI, OP_SLLI, OP_SRLI, OP_SRAI, OP_SLTI, OP_SLTIU,
        OP_LUI    = 6'd19,
        OP_AUIPC,
        OP_JAL    = 6'd21,
        OP_JALR,
        OP_BEQ    = 6'd23,
        OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_MUL    = 6'd29,
        OP_MULH, OP_MULHSU, OP_MULHU
    } alu_op_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_e;

    // Observation point for checkers: FSM state and FIFO occupancy.
    typedef struct packed {
        alu_state_e state;
        logic [7:0] count;
    } alu_dbg_t;

    function automatic logic is_mul_op(input logic [OP_WIDTH-1:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
    endfunction

endpackage

// File: rtl/alu_unit_core.sv
// Single-cycle combinational ALU datapath: result, next PC and taken flag for one op.
// Multiply opcodes are not handled here and fall through to the unknown-opcode path.
module alu_unit_core
    import alu_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic [OP_WIDTH-1:0]   opcode,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic [DATA_WIDTH-1:0] vj,
    input  logic [DATA_WIDTH-1:0] vk,
    input  logic [DATA_WIDTH-1:0] imm,
    output logic [DATA_WIDTH-1:0] result,
    output logic [ADDR_WIDTH-1:0] new_pc,
    output logic                  taken
);

    localparam int SH_W = $clog2(DATA_WIDTH);

    logic [SH_W-1:0]       sh_r;
    logic [SH_W-1:0]       sh_i;
    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic [ADDR_WIDTH-1:0] pc_imm;
    logic                  cond;

    assign sh_r     = vk[SH_W-1:0];
    assign sh_i     = imm[SH_W-1:0];
    assign pc_plus4 = pc + ADDR_WIDTH'(4);
    assign pc_imm   = pc + ADDR_WIDTH'($signed(imm));

    always_comb begin
        cond = 1'b0;
        case (opcode)
            OP_BEQ:  cond = (vj == vk);
            OP_BNE:  cond = (vj != vk);
            OP_BLT:  cond = ($signed(vj) < $signed(vk));
            OP_BGE:  cond = ($signed(vj) >= $signed(vk));
            OP_BLTU: cond = (vj < vk);
            OP_BGEU: cond = (vj >= vk);
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        result = '0;
        new_pc = pc_plus4;
        taken  = 1'b0;
        case (opcode)
            OP_ADD:   result = vj + vk;
            OP_SUB:   result = vj - vk;
            OP_AND:   result = vj & vk;
            OP_OR:    result = vj | vk;
            OP_XOR:   result = vj ^ vk;
            OP_SLL:   result = vj << sh_r;
            OP_SRL:   result = vj >> sh_r;
            OP_SRA:   result = $signed(vj) >>> sh_r;
            OP_SLT:   result = {{(DATA_WIDTH-1){1'b0}}, ($signed(vj) < $signed(vk))};
            OP_SLTU:  result = {{(DATA_WIDTH-1){1'b0}}, (vj < vk)};
            OP_ADDI:  result = vj + imm;
            OP_ANDI:  result = vj & imm;
            OP_ORI:   result = vj | imm;
            OP_XORI:  result = vj ^ imm;
            OP_SLLI:  result = vj << sh_i;
            OP_SRLI:  result = vj >> sh_i;
            OP_SRAI:  result = $signed(vj) >>> sh_i;
            OP_SLTI:  result = {{(DATA_WIDTH-1){1'b0}}, ($signed(vj) < $signed(imm))};
            OP_SLTIU: result = {{(DATA_WIDTH-1){1'b0}}, (vj < imm)};
            OP_LUI:   result = imm;
            OP_AUIPC: result = DATA_WIDTH'(pc_imm);
            OP_JAL: begin
                result = DATA_WIDTH'(pc_plus4);
                new_pc = pc_imm;
                taken  = 1'b1;
            end
            OP_JALR: begin
                result = DATA_WIDTH'(pc_plus4);
                new_pc = ADDR_WIDTH'(vj + imm) & {{(ADDR_WIDTH-1){1'b1}}, 1'b0};
                taken  = 1'b1;
            end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                result = {{(DATA_WIDTH-1){1'b0}}, cond};
                new_pc = cond ? pc_imm : pc_plus4;
                taken  = cond;
            end
            default: begin
                result = '0;
                new_pc = pc_plus4;
                taken  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_unit.sv
// ALU execute unit: valid/ready issue from the RS, in-order output FIFO toward the CDB, flush support.
// Define ALU_MUL_EN to build the multi-cycle multiplier and its IDLE/MUL FSM.
module alu_unit
    import alu_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ROB_WIDTH  = 4,
    parameter int OUT_DEPTH  = 2,
    parameter int MUL_LAT    = 3
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  flush_in,
    input  logic                  valid_rs_in,
    output logic                  ready_rs_out,
    input  logic [OP_WIDTH-1:0]   opcode_rs_in,
    input  logic [ADDR_WIDTH-1:0] pc_rs_in,
    input  logic [DATA_WIDTH-1:0] vj_rs_in,
    input  logic [DATA_WIDTH-1:0] vk_rs_in,
    input  logic [DATA_WIDTH-1:0] imm_rs_in,
    input  logic [ROB_WIDTH-1:0]  rob_id_rs_in,
    output logic                  valid_cdb_out,
    input  logic                  grant_cdb_in,
    output logic [DATA_WIDTH-1:0] result_cdb_out,
    output logic [ADDR_WIDTH-1:0] new_pc_cdb_out,
    output logic                  taken_cdb_out,
    output logic [ROB_WIDTH-1:0]  rob_id_cdb_out,
    output alu_dbg_t              dbg
);

    // Handshakes: an op transfers on a clk edge where valid_rs_in && ready_rs_out && !flush_in;
    // the head entry leaves on an edge where valid_cdb_out && grant_cdb_in && !flush_in.

    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CNT_W = $clog2(OUT_DEPTH + 1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] result;
        logic [ADDR_WIDTH-1:0] new_pc;
        logic                  taken;
        logic [ROB_WIDTH-1:0]  rob_id;
    } entry_t;

    entry_t           mem [OUT_DEPTH];
    entry_t           head;
    entry_t           core_entry;
    entry_t           push_entry;
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;
    alu_state_e       state_q;
    alu_state_e       state_d;
    logic             full;
    logic             accept;
    logic             pop;
    logic             push;

    logic [DATA_WIDTH-1:0] core_result;
    logic [ADDR_WIDTH-1:0] core_new_pc;
    logic                  core_taken;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    alu_unit_core #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_core (
        .opcode(opcode_rs_in),
        .pc    (pc_rs_in),
        .vj    (vj_rs_in),
        .vk    (vk_rs_in),
        .imm   (imm_rs_in),
        .result(core_result),
        .new_pc(core_new_pc),
        .taken (core_taken)
    );

    assign core_entry = {core_result, core_new_pc, core_taken, rob_id_rs_in};

    assign full          = (count_q == CNT_W'(OUT_DEPTH));
    assign ready_rs_out  = rst_in && rdy_in && (state_q == ST_IDLE) && !full;
    assign valid_cdb_out = rdy_in && (count_q != '0);
    assign accept        = valid_rs_in && ready_rs_out && !flush_in;
    assign pop           = valid_cdb_out && grant_cdb_in && !flush_in;

    assign head           = mem[head_q];
    assign result_cdb_out = head.result;
    assign new_pc_cdb_out = head.new_pc;
    assign taken_cdb_out  = head.taken;
    assign rob_id_cdb_out = head.rob_id;

    assign dbg.state = state_q;
    assign dbg.count = 8'(count_q);

`ifdef ALU_MUL_EN
    localparam int MC_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    logic [MC_W-1:0]         mul_cnt_q;
    logic [MC_W-1:0]         mul_cnt_d;
    logic                    mul_start;
    logic [OP_WIDTH-1:0]     mul_op_q;
    logic [ADDR_WIDTH-1:0]   mul_pc_q;
    logic [DATA_WIDTH-1:0]   mul_a_q;
    logic [DATA_WIDTH-1:0]   mul_b_q;
    logic [ROB_WIDTH-1:0]    mul_rob_q;
    logic [OP_WIDTH-1:0]     m_op;
    logic [ADDR_WIDTH-1:0]   m_pc;
    logic [DATA_WIDTH-1:0]   m_vj;
    logic [DATA_WIDTH-1:0]   m_vk;
    logic [ROB_WIDTH-1:0]    m_rob;
    logic                    m_sa;
    logic                    m_sb;
    logic [2*DATA_WIDTH-1:0] m_a;
    logic [2*DATA_WIDTH-1:0] m_b;
    logic [2*DATA_WIDTH-1:0] m_prod;
    entry_t                  mul_entry;

    // Operands come from the latch while in MUL; straight from the RS when MUL_LAT==1 completes at accept.
    always_comb begin
        m_op  = (state_q == ST_MUL) ? mul_op_q  : opcode_rs_in;
        m_pc  = (state_q == ST_MUL) ? mul_pc_q  : pc_rs_in;
        m_vj  = (state_q == ST_MUL) ? mul_a_q   : vj_rs_in;
        m_vk  = (state_q == ST_MUL) ? mul_b_q   : vk_rs_in;
        m_rob = (state_q == ST_MUL) ? mul_rob_q : rob_id_rs_in;
        m_sa  = (m_op == OP_MULH) || (m_op == OP_MULHSU);
        m_sb  = (m_op == OP_MULH);
        m_a   = {{DATA_WIDTH{m_vj[DATA_WIDTH-1] & m_sa}}, m_vj};
        m_b   = {{DATA_WIDTH{m_vk[DATA_WIDTH-1] & m_sb}}, m_vk};
        m_prod = m_a * m_b;
        mul_entry.result = (m_op == OP_MUL) ? m_prod[DATA_WIDTH-1:0] : m_prod[2*DATA_WIDTH-1:DATA_WIDTH];
        mul_entry.new_pc = m_pc + ADDR_WIDTH'(4);
        mul_entry.taken  = 1'b0;
        mul_entry.rob_id = m_rob;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            mul_cnt_q <= '0;
            mul_op_q  <= '0;
            mul_pc_q  <= '0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            mul_rob_q <= '0;
        end else if (rdy_in) begin
            mul_cnt_q <= flush_in ? '0 : mul_cnt_d;
            if (mul_start) begin
                mul_op_q  <= opcode_rs_in;
                mul_pc_q  <= pc_rs_in;
                mul_a_q   <= vj_rs_in;
                mul_b_q   <= vk_rs_in;
                mul_rob_q <= rob_id_rs_in;
            end
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        push       = 1'b0;
        push_entry = core_entry;
`ifdef ALU_MUL_EN
        mul_start  = 1'b0;
        mul_cnt_d  = mul_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!is_mul_op(opcode_rs_in)) begin
                        push = 1'b1;
                    end else if (MUL_LAT == 1) begin
                        push       = 1'b1;
                        push_entry = mul_entry;
                    end else begin
                        state_d   = ST_MUL;
                        mul_start = 1'b1;
                        mul_cnt_d = '0;
                    end
                end
            end
            ST_MUL: begin
                // Final cycle: push only when a slot exists (or frees this edge), else keep waiting.
                if (mul_cnt_q == MC_W'(MUL_LAT - 2)) begin
                    if (!full || pop) begin
                        push       = 1'b1;
                        push_entry = mul_entry;
                        state_d    = ST_IDLE;
                    end
                end else begin
                    mul_cnt_d = mul_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
`else
        push = accept;
`endif
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            state_q <= ST_IDLE;
            for (int i = 0; i < OUT_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (rdy_in) begin
            if (flush_in) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
                state_q <= ST_IDLE;
            end else begin
                state_q <= state_d;
                if (push) begin
                    mem[tail_q] <= push_entry;
                    tail_q      <= ptr_inc(tail_q);
                end
                if (pop) begin
                    head_q <= ptr_inc(head_q);
                end
                if (push && !pop) begin
                    count_q <= count_q + 1'b1;
                end else if (pop && !push) begin
                    count_q <= count_q - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_unit.sv
// Directed self-checking bench for alu_unit: single-cycle ops, branches/jumps, backpressure,
// flush, freeze and reset; multiply checks are compiled in when ALU_MUL_EN is defined.
module tb_alu_unit;
    import alu_unit_pkg::*;

    logic                clk_in;
    logic                rst_in;
    logic                rdy_in;
    logic                flush_in;
    logic                valid_rs_in;
    logic                ready_rs_out;
    logic [OP_WIDTH-1:0] opcode_rs_in;
    logic [31:0]         pc_rs_in;
    logic [31:0]         vj_rs_in;
    logic [31:0]         vk_rs_in;
    logic [31:0]         imm_rs_in;
    logic [3:0]          rob_id_rs_in;
    logic                valid_cdb_out;
    logic                grant_cdb_in;
    logic [31:0]         result_cdb_out;
    logic [31:0]         new_pc_cdb_out;
    logic                taken_cdb_out;
    logic [3:0]          rob_id_cdb_out;
    alu_dbg_t            dbg;

    int errors = 0;
    int checks = 0;
    logic [35:0] exp_q[$];
    logic [35:0] exp_e;

    alu_unit dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .flush_in      (flush_in),
        .valid_rs_in   (valid_rs_in),
        .ready_rs_out  (ready_rs_out),
        .opcode_rs_in  (opcode_rs_in),
        .pc_rs_in      (pc_rs_in),
        .vj_rs_in      (vj_rs_in),
        .vk_rs_in      (vk_rs_in),
        .imm_rs_in     (imm_rs_in),
        .rob_id_rs_in  (rob_id_rs_in),
        .valid_cdb_out (valid_cdb_out),
        .grant_cdb_in  (grant_cdb_in),
        .result_cdb_out(result_cdb_out),
        .new_pc_cdb_out(new_pc_cdb_out),
        .taken_cdb_out (taken_cdb_out),
        .rob_id_cdb_out(rob_id_cdb_out),
        .dbg           (dbg)
    );

    // ---- clock / reset ----
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // ---- driver tasks ----
    task automatic drive(input logic [OP_WIDTH-1:0] op, input logic [31:0] pc, input logic [31:0] vj,
                         input logic [31:0] vk, input logic [31:0] imm, input logic [3:0] rob);
        opcode_rs_in = op;
        pc_rs_in     = pc;
        vj_rs_in     = vj;
        vk_rs_in     = vk;
        imm_rs_in    = imm;
        rob_id_rs_in = rob;
    endtask

    task automatic pop_head();
        grant_cdb_in = 1'b1;
        tick();
        grant_cdb_in = 1'b0;
    endtask

    // ---- scoreboard comparison ----
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [OP_WIDTH-1:0] op, input logic [31:0] pc,
                          input logic [31:0] vj, input logic [31:0] vk, input logic [31:0] imm,
                          input logic [3:0] rob, input logic [31:0] e_res, input logic [31:0] e_pc,
                          input logic e_taken);
        check({tag, "_ready"}, ready_rs_out, 1);
        drive(op, pc, vj, vk, imm, rob);
        valid_rs_in = 1'b1;
        tick();
        valid_rs_in = 1'b0;
        check({tag, "_valid"}, valid_cdb_out, 1);
        check({tag, "_result"}, result_cdb_out, e_res);
        check({tag, "_new_pc"}, new_pc_cdb_out, e_pc);
        check({tag, "_taken"}, taken_cdb_out, e_taken);
        check({tag, "_rob"}, rob_id_cdb_out, rob);
        pop_head();
        check({tag, "_drained"}, valid_cdb_out, 0);
    endtask

    task automatic check_outs_zero(input string tag);
        check({tag, "_valid"}, valid_cdb_out, 0);
        check({tag, "_result"}, result_cdb_out, 0);
        check({tag, "_new_pc"}, new_pc_cdb_out, 0);
        check({tag, "_taken"}, taken_cdb_out, 0);
        check({tag, "_rob"}, rob_id_cdb_out, 0);
    endtask

    initial begin
        rst_in       = 1'b0;
        rdy_in       = 1'b1;
        flush_in     = 1'b0;
        valid_rs_in  = 1'b0;
        grant_cdb_in = 1'b0;
        drive(6'd0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0);

        // Reset state
        tick();
        tick();
        check("rst_ready", ready_rs_out, 0);
        check_outs_zero("rst");
        check("rst_count", dbg.count, 0);
        check("rst_state", dbg.state, ST_IDLE);
        rst_in = 1'b1;
        #1;

        // Single-cycle ops, latency 1
        run_op("add",   OP_ADD,   32'h1000, 32'd5,        32'd7,        32'd0,        4'd3, 32'd12,       32'h1004, 1'b0);
        run_op("sub",   OP_SUB,   32'h1000, 32'd5,        32'd7,        32'd0,        4'd4, 32'hFFFF_FFFE, 32'h1004, 1'b0);
        run_op("sra",   OP_SRA,   32'h1004, 32'h8000_0000, 32'd33,      32'd0,        4'd5, 32'hC000_0000, 32'h1008, 1'b0);
        run_op("srl",   OP_SRL,   32'h1004, 32'h8000_0000, 32'd4,       32'd0,        4'd6, 32'h0800_0000, 32'h1008, 1'b0);
        run_op("sltu",  OP_SLTU,  32'h1008, 32'd1,        32'hFFFF_FFFF, 32'd0,       4'd7, 32'd1,        32'h100C, 1'b0);
        run_op("slt",   OP_SLT,   32'h1008, 32'd1,        32'hFFFF_FFFF, 32'd0,       4'd8, 32'd0,        32'h100C, 1'b0);
        run_op("slli",  OP_SLLI,  32'h1010, 32'd1,        32'd0,        32'd31,       4'd9, 32'h8000_0000, 32'h1014, 1'b0);
        run_op("bne",   OP_BNE,   32'h0100, 32'd1,        32'd2,        32'h20,       4'd1, 32'd1,        32'h0120, 1'b1);
        run_op("beq",   OP_BEQ,   32'h0100, 32'd1,        32'd2,        32'h20,       4'd2, 32'd0,        32'h0104, 1'b0);
        run_op("blt",   OP_BLT,   32'h0200, 32'hFFFF_FFFF, 32'd0,       32'hFFFF_FFF0, 4'd3, 32'd1,       32'h01F0, 1'b1);
        run_op("jalr",  OP_JALR,  32'h0040, 32'h203,      32'd0,        32'd0,        4'd4, 32'h44,       32'h0202, 1'b1);
        run_op("jal",   OP_JAL,   32'h0040, 32'd0,        32'd0,        32'h100,      4'd5, 32'h44,       32'h0140, 1'b1);
        run_op("unk",   6'd63,    32'h0500, 32'd5,        32'd6,        32'd7,        4'd6, 32'd0,        32'h0504, 1'b0);
`ifndef ALU_MUL_EN
        run_op("mulhu_unk", OP_MULHU, 32'h0600, 32'hFFFF_FFFF, 32'd2, 32'd0, 4'd7, 32'd0, 32'h0604, 1'b0);
`endif

        // Backpressure: grant low, three back-to-back issues into a 2-deep FIFO
        exp_q = {};
        drive(OP_ADD, 32'h2000, 32'd1, 32'd1, 32'd0, 4'd1);
        valid_rs_in = 1'b1;
        tick();
        exp_q.push_back({4'd1, 32'd2});
        check("bp_ready_after1", ready_rs_out, 1);
        drive(OP_ADD, 32'h2004, 32'd2, 32'd2, 32'd0, 4'd2);
        tick();
        exp_q.push_back({4'd2, 32'd4});
        check("bp_ready_full", ready_rs_out, 0);
        drive(OP_ADD, 32'h2008, 32'd3, 32'd3, 32'd0, 4'd3);
        tick();
        check("bp_held_ready", ready_rs_out, 0);
        check("bp_held_count", dbg.count, 2);
        exp_e = exp_q.pop_front();
        check("bp_head_result", result_cdb_out, exp_e[31:0]);
        check("bp_head_rob", rob_id_cdb_out, exp_e[35:32]);
        pop_head();
        check("bp_slot_freed", ready_rs_out, 1);
        tick();
        valid_rs_in = 1'b0;
        exp_q.push_back({4'd3, 32'd6});
        check("bp_count_refill", dbg.count, 2);
        while (exp_q.size() > 0) begin
            exp_e = exp_q.pop_front();
            check("bp_drain_valid", valid_cdb_out, 1);
            check("bp_drain_result", result_cdb_out, exp_e[31:0]);
            check("bp_drain_rob", rob_id_cdb_out, exp_e[35:32]);
            pop_head();
        end
        check("bp_empty", valid_cdb_out, 0);

        // Push and pop in the same cycle keep the count
        drive(OP_ADD, 32'h3000, 32'd10, 32'd0, 32'd0, 4'd5);
        valid_rs_in = 1'b1;
        tick();
        drive(OP_ADD, 32'h3004, 32'd20, 32'd0, 32'd0, 4'd6);
        grant_cdb_in = 1'b1;
        tick();
        valid_rs_in  = 1'b0;
        grant_cdb_in = 1'b0;
        check("pp_count", dbg.count, 1);
        check("pp_result", result_cdb_out, 20);
        check("pp_rob", rob_id_cdb_out, 6);

        // rdy_in low freezes everything
        rdy_in = 1'b0;
        #1;
        check("frz_valid", valid_cdb_out, 0);
        check("frz_ready", ready_rs_out, 0);
        drive(OP_ADD, 32'h3008, 32'd99, 32'd0, 32'd0, 4'd7);
        valid_rs_in  = 1'b1;
        grant_cdb_in = 1'b1;
        tick();
        valid_rs_in  = 1'b0;
        grant_cdb_in = 1'b0;
        rdy_in       = 1'b1;
        #1;
        check("frz_count", dbg.count, 1);
        check("frz_valid_after", valid_cdb_out, 1);
        check("frz_result_after", result_cdb_out, 20);

        // Flush with two entries buffered and a new op presented
        drive(OP_ADD, 32'h300C, 32'd30, 32'd0, 32'd0, 4'd8);
        valid_rs_in = 1'b1;
        tick();
        check("fl_prefill_count", dbg.count, 2);
        drive(OP_ADD, 32'h3010, 32'd40, 32'd0, 32'd0, 4'd9);
        flush_in     = 1'b1;
        grant_cdb_in = 1'b1;
        tick();
        flush_in     = 1'b0;
        valid_rs_in  = 1'b0;
        grant_cdb_in = 1'b0;
        check("fl_valid", valid_cdb_out, 0);
        check("fl_count", dbg.count, 0);
        check("fl_ready", ready_rs_out, 1);
        tick();
        check("fl_op_dropped", valid_cdb_out, 0);

        // Reset with data buffered clears the outputs
        drive(OP_ADD, 32'h4000, 32'd77, 32'd0, 32'd0, 4'd10);
        valid_rs_in = 1'b1;
        tick();
        valid_rs_in = 1'b0;
        check("rst2_pre_valid", valid_cdb_out, 1);
        rst_in = 1'b0;
        tick();
        rst_in = 1'b1;
        #1;
        check_outs_zero("rst2");
        check("rst2_ready", ready_rs_out, 1);

`ifdef ALU_MUL_EN
        // MULHU with MUL_LAT=3: ready low while busy, result visible three cycles after accept
        drive(OP_MULHU, 32'h0300, 32'hFFFF_FFFF, 32'd2, 32'd0, 4'd7);
        valid_rs_in = 1'b1;
        tick();
        valid_rs_in = 1'b0;
        check("mul_c1_ready", ready_rs_out, 0);
        check("mul_c1_valid", valid_cdb_out, 0);
        check("mul_c1_state", dbg.state, ST_MUL);
        tick();
        check("mul_c2_ready", ready_rs_out, 0);
        check("mul_c2_valid", valid_cdb_out, 0);
        tick();
        check("mul_c3_valid", valid_cdb_out, 1);
        check("mul_c3_result", result_cdb_out, 1);
        check("mul_c3_new_pc", new_pc_cdb_out, 32'h0304);
        check("mul_c3_rob", rob_id_cdb_out, 7);
        check("mul_c3_ready", ready_rs_out, 1);
        pop_head();

        // Low-half multiply
        drive(OP_MUL, 32'h0310, 32'd6, 32'd7, 32'd0, 4'd2);
        valid_rs_in = 1'b1;
        tick();
        valid_rs_in = 1'b0;
        tick();
        tick();
        check("mul_lo_valid", valid_cdb_out, 1);
        check("mul_lo_result", result_cdb_out, 42);
        pop_head();

        // Reset in the middle of a multiply discards it
        drive(OP_MULHU, 32'h0320, 32'hFFFF_FFFF, 32'd2, 32'd0, 4'd9);
        valid_rs_in = 1'b1;
        tick();
        valid_rs_in = 1'b0;
        rst_in = 1'b0;
        tick();
        rst_in = 1'b1;
        #1;
        check("mulrst_state", dbg.state, ST_IDLE);
        tick();
        tick();
        tick();
        check_outs_zero("mulrst");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
